// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared widths, counter sizing and FSM state encoding for the
//               weight-stationary systolic array.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  // Default operand and accumulator widths
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 17;

  // RUN phase cycle counter: counts 0..3
  localparam int unsigned      CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = 2'd3;

  // Sequencer states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/processing_element.sv
`default_nettype none
// ============================================================================
// Module      : processing_element
// Description : One weight-stationary MAC cell. Holds a weight, forwards the
//               activation one cycle later and adds act*w to the incoming
//               partial sum.
// Revision    : 1.0 - initial release
// ============================================================================
module processing_element
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] act_in,
  output logic [DATA_W-1:0] act_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0]   w_q;
  logic [DATA_W-1:0]   act_q;
  logic [ACC_W-1:0]    psum_q;
  logic [ACC_W-1:0]    psum_d;
  logic [2*DATA_W-1:0] prod_d;

  // Unsigned product zero-extended into the accumulator width
  always_comb begin
    prod_d = {{DATA_W{1'b0}}, act_in} * {{DATA_W{1'b0}}, w_q};
    psum_d = psum_in + {{(ACC_W-2*DATA_W){1'b0}}, prod_d};
  end

  // Weight register plus activation/partial-sum pipeline registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_q    <= '0;
      act_q  <= '0;
      psum_q <= '0;
    end else begin
      if (w_load) begin
        w_q <= w_in;
      end
      act_q  <= act_in;
      psum_q <= psum_d;
    end
  end

  assign act_out  = act_q;
  assign psum_out = psum_q;

endmodule : processing_element
`default_nettype wire

// File: rtl/systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array
// Description : 2x2 weight-stationary systolic array. Skewed activations flow
//               right, partial sums flow down; column 0 is delayed one cycle
//               so each result row leaves aligned, with valid/row/done flags.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_w,
  input  logic [DATA_W-1:0] w00,
  input  logic [DATA_W-1:0] w01,
  input  logic [DATA_W-1:0] w10,
  input  logic [DATA_W-1:0] w11,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in1,
  input  logic [DATA_W-1:0] a_in2,
  output logic [ACC_W-1:0]  c_out0,
  output logic [ACC_W-1:0]  c_out1,
  output logic              out_row,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_en;
  logic             w_load_en;

  logic [DATA_W-1:0] act_row0_in, act_row1_in;
  logic [DATA_W-1:0] act00_out, act10_out;
  // East edge of the array: nothing consumes these activations
  logic [DATA_W-1:0] act01_unused, act11_unused;
  logic [ACC_W-1:0]  psum00, psum01, psum10, psum11;

  logic [ACC_W-1:0] deskew_q;
  logic [ACC_W-1:0] c_out0_q, c_out0_d;
  logic [ACC_W-1:0] c_out1_q, c_out1_d;
  logic             out_valid_q, out_valid_d;
  logic             out_row_q, out_row_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             first_row, last_row;

  // Sequencer state and cycle counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a weight load in IDLE takes priority over start
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gate_en   = 1'b0;
    w_load_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_w) begin
          w_load_en = 1'b1;
        end else if (start) begin
          gate_en = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        gate_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign act_row0_in = gate_en ? a_in1 : '0;
  assign act_row1_in = gate_en ? a_in2 : '0;

  processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe00 (
    .clk(clk), .reset(reset), .w_load(w_load_en), .w_in(w00),
    .act_in(act_row0_in), .act_out(act00_out),
    .psum_in({ACC_W{1'b0}}), .psum_out(psum00)
  );

  processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe01 (
    .clk(clk), .reset(reset), .w_load(w_load_en), .w_in(w01),
    .act_in(act00_out), .act_out(act01_unused),
    .psum_in({ACC_W{1'b0}}), .psum_out(psum01)
  );

  processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe10 (
    .clk(clk), .reset(reset), .w_load(w_load_en), .w_in(w10),
    .act_in(act_row1_in), .act_out(act10_out),
    .psum_in(psum00), .psum_out(psum10)
  );

  processing_element #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe11 (
    .clk(clk), .reset(reset), .w_load(w_load_en), .w_in(w11),
    .act_in(act10_out), .act_out(act11_unused),
    .psum_in(psum01), .psum_out(psum11)
  );

  // Row 0 lands in the output registers at cnt=2, row 1 at cnt=3
  always_comb begin
    first_row   = (state_q == RUN) && (cnt_q == CNT_LAST - 1'b1);
    last_row    = (state_q == RUN) && (cnt_q == CNT_LAST);
    out_valid_d = first_row || last_row;
    out_row_d   = last_row;
    done_d      = last_row;
    busy_d      = (state_d == RUN) || done_d;
    c_out0_d    = out_valid_d ? deskew_q : c_out0_q;
    c_out1_d    = out_valid_d ? psum11   : c_out1_q;
  end

  // Column-0 de-skew register and the result/handshake output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      deskew_q    <= '0;
      c_out0_q    <= '0;
      c_out1_q    <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      deskew_q    <= psum10;
      c_out0_q    <= c_out0_d;
      c_out1_q    <= c_out1_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign c_out0    = c_out0_q;
  assign c_out1    = c_out1_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule : systolic_array
`default_nettype wire

// File: doc/systolic_array.md
# systolic_array

Weight-stationary 2×2 systolic array that consumes the skewed activation streams produced by the activation-skew stage (`a_in1` for array row 0, `a_in2` for array row 1, one cycle behind). Weights are preloaded, then activations flow right and partial sums flow down. Column outputs are de-skewed internally and emitted one result row per cycle with a valid/done handshake toward the accumulator/writeback stage.

## Interface
- `DATA_W`, 8: activation and weight width, unsigned.
- `ACC_W`, 17: partial-sum and result width; must be ≥ 2·DATA_W+1.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low; clears all state when low at a rising edge.
- `load_w` input 1: single-cycle weight-load strobe.
- `w00`, `w01`, `w10`, `w11` input DATA_W each: weights, `wkj` lands in PE(k,j).
- `start` input 1: pulse, asserted in the cycle `a_in1` carries x0[0].
- `a_in1` input DATA_W: row-0 activation stream x0[0], x0[1], 0.
- `a_in2` input DATA_W: row-1 activation stream 0, x1[0], x1[1].
- `c_out0`, `c_out1` output ACC_W: result row, columns 0 and 1.
- `out_row` output 1: index m of the current result row.
- `out_valid` output 1: `c_out*`/`out_row` valid this cycle.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse with the last result row.

## Operation
- Result: c[m][j] = x0[m]·w0j + x1[m]·w1j, unsigned, modulo 2^ACC_W.
- PE(k,j): registers act_out ← act_in and psum_out ← psum_in + act_in·w. Row-0 psum_in = 0. Column-0 act_in = array input. Column-1 act_in = PE(k,0).act_out.
- Array inputs are gated: `a_in1`/`a_in2` enter only in the `start` cycle and while in RUN. Otherwise zero is injected.
- FSM states:
  - IDLE: `busy`=0. `load_w` captures all four weights. `start` moves to RUN with cycle counter cnt=0.
  - RUN: cnt increments 0..3. After cnt=3 the FSM returns to IDLE.
- `load_w` is ignored outside IDLE. `start` is ignored outside IDLE.
- If `load_w` and `start` are both high in IDLE, the load is accepted and `start` is ignored.
- De-skew: column-0 bottom psum passes through one extra register, so both columns reach the output registers aligned.
- Reset (any state, including mid-RUN): weights, PE registers, de-skew register, and counter cleared to 0; FSM goes to IDLE. Every output resets to 0.

## Timing
- Let E0 be the edge sampling `start`=1 together with x0[0].
- Input samples: E1 samples x0[1] and x1[0]. E2 samples x1[1].
- Internal results:
  - c[0][0] is at the PE(1,0) output after E1. c[0][1] is at PE(1,1) after E2.
  - c[1][0] is after E2. c[1][1] is after E3.
- Outputs:
  - After E3: `out_valid`=1, `out_row`=0, c[0][*].
  - After E4: `out_valid`=1, `out_row`=1, c[1][*], `done`=1.
  - After E5: `out_valid`=`done`=0.
- Latency is 3 cycles from x0[m] to result row m. Rows are back-to-back.
- `busy` is high from after E0 through the cycle after E4 (the done cycle) inclusive.
- The earliest next `start` is accepted at E5.
- Weights loaded at edge L are usable by a `start` at L+1.
- `c_out*` hold their last value when `out_valid`=0.

## Structure
- Package `tpu_pkg`:
  - DATA_W/ACC_W defaults.
  - FSM state enum (IDLE, RUN).
  - Counter width constant.
- Sub-module `processing_element`, instantiated 4×:
  - Ports: weight load, act in/out, psum in/out, clk/reset.
- The top level holds the FSM, input gating, de-skew register, and output registers.

## Test plan
- Load W=[[1,2],[3,4]], start with x0=[5,6], x1=[7,8].
  - After E3: row 0 = (26,38).
  - After E4: row 1 = (30,44) with `done`=1.
- All weights and activations 255.
  - Every result = 130050, with no overflow at ACC_W=17.
- `start` pulsed at E2 during RUN.
  - It is ignored: outputs match the single-run results and `busy` drops on schedule.
- `load_w` during RUN with all-zero weights.
  - It is ignored: the current and the next run still use the old weights.
- `reset` low at E2.
  - After E2 all outputs are 0, the FSM is IDLE, and weights are 0.
  - A subsequent run without reload produces zeros.
- `load_w` and `start` high together in IDLE.
  - Weights update and no run starts (`busy` stays 0).
  - A `start` one cycle later uses the new weights.
